// File: rtl/ram_rw_arbiter.sv
// Round-robin arbiter and op sequencer in front of a single-port RW RAM.
// Serves one request at a time (issue, capture, ack) and runs full-memory clear sweeps.
module ram_rw_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_req,
  output logic                  clr_busy,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_sel,
  output logic                  ram_clr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPT, ACK, CLEAR} state_t;

  state_t                state_reg, state_next;
  logic                  gnt_b_reg, gnt_b_next;   // current grant: 1 = B
  logic                  rr_b_reg, rr_b_next;     // last granted: 1 = B
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] din_reg, din_next;
  logic [ADDR_WIDTH-1:0] clr_cnt_reg, clr_cnt_next;
  logic [DATA_WIDTH-1:0] a_rdata_reg, b_rdata_reg;
  logic                  pick_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      gnt_b_reg   <= 1'b0;
      rr_b_reg    <= 1'b1;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      din_reg     <= '0;
      clr_cnt_reg <= '0;
      a_rdata_reg <= '0;
      b_rdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      gnt_b_reg   <= gnt_b_next;
      rr_b_reg    <= rr_b_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      din_reg     <= din_next;
      clr_cnt_reg <= clr_cnt_next;
      // RAM output is valid during CAPT for reads issued in the previous cycle
      if (state_reg == CAPT && !we_reg) begin
        if (gnt_b_reg) b_rdata_reg <= ram_dout;
        else           a_rdata_reg <= ram_dout;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    gnt_b_next   = gnt_b_reg;
    rr_b_next    = rr_b_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    din_next     = din_reg;
    clr_cnt_next = clr_cnt_reg;
    clr_busy     = 1'b0;
    a_ack        = 1'b0;
    b_ack        = 1'b0;
    ram_sel      = 1'b0;
    ram_clr      = 1'b0;
    ram_addr     = '0;
    ram_din      = '0;
    pick_b       = b_req & (~a_req | ~rr_b_reg);

    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
        end else if (a_req || b_req) begin
          gnt_b_next = pick_b;
          rr_b_next  = pick_b;
          we_next    = pick_b ? b_we   : a_we;
          addr_next  = pick_b ? b_addr : a_addr;
          din_next   = pick_b ? b_din  : a_din;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        ram_sel    = we_reg;
        ram_addr   = addr_reg;
        ram_din    = din_reg;
        state_next = CAPT;
      end
      CAPT: state_next = ACK;
      ACK: begin
        a_ack      = ~gnt_b_reg;
        b_ack      = gnt_b_reg;
        state_next = IDLE;
      end
      CLEAR: begin
        clr_busy     = 1'b1;
        ram_clr      = 1'b1;
        ram_addr     = clr_cnt_reg;
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == {ADDR_WIDTH{1'b1}}) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign a_rdata = a_rdata_reg;
  assign b_rdata = b_rdata_reg;

endmodule
